stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Front-end controller for the stopwatch counter; turns raw push-buttons into the stopwatch mode code.
- Debounces three raw buttons (start/stop, lap, clear) and runs a run/pause/lap state machine.
- Drives the stopwatch's 3-bit mode input tag1: 0 = hold, 1 = count, 2 = clear.
- Latches lap (split) values and selects the 32-bit value sent to the display path.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); benches override to 4.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
btn_start  in  1  raw start/stop button, active-high, asynchronous
btn_lap  in  1  raw lap button, active-high, asynchronous
btn_clear  in  1  raw clear button, active-high, asynchronous
sw_count  in  32  current stopwatch count (tenths), from the stopwatch
tag1  out  3  registered mode to stopwatch: 0 hold, 1 count, 2 clear
display  out  32  value for display: lap_reg in LAP, else sw_count (combinational mux)
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
lap_valid  out  1  high once a lap has been captured since the last clear/reset

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Per-button conditioning:
  - Two-flop synchronizer, s1 then s2.
  - Debounced level deb and counter cnt. If s2 == deb: cnt <= 0. If s2 != deb: cnt increments; when cnt == DEBOUNCE_CYCLES-1, deb <= s2 and cnt <= 0.
  - press = deb & ~deb_d, where deb_d is deb delayed one cycle. press is high for exactly one cycle per debounced rising edge.
  - A held button never re-triggers. A pulse shorter than DEBOUNCE_CYCLES cycles at s2 is ignored. Falling edges are debounced the same way but produce no press.
- Latency: if raw goes high before edge E0 and stays high, the FSM and tag1 update on edge E0 + DEBOUNCE_CYCLES + 2. With DEBOUNCE_CYCLES=4, the update lands on the 7th edge counting E0 as the 1st.
- Press priority when pulses coincide: clear > start > lap. Only the highest-priority press acts in that cycle; the others are discarded.
- Transitions (tag1 is registered alongside state):
  - Any state, clear: state <= IDLE, tag1 <= 2 for exactly one cycle, lap_valid <= 0, lap_reg <= 0. On the following cycle tag1 <= 0.
  - IDLE, start: RUN, tag1 <= 1. Lap is ignored.
  - RUN, start: PAUSE, tag1 <= 0.
  - RUN, lap: LAP, lap_reg <= sw_count (value on that edge), lap_valid <= 1. tag1 stays 1.
  - LAP, lap: RUN, display returns to live sw_count. lap_reg and lap_valid are kept.
  - LAP, start: PAUSE, tag1 <= 0.
  - PAUSE, start: RUN, tag1 <= 1. Lap is ignored.
- display: combinational. Equals lap_reg while state == LAP, otherwise sw_count.
- sw_count is passed through unmodified; wrap past 9999 is the stopwatch's responsibility.
- Reset (edge with rst high):
  - state <= IDLE, tag1 <= 2, lap_reg <= 0, lap_valid <= 0.
  - All synchronizer, deb, deb_d and cnt registers <= 0.
  - tag1 = 2 is held for every reset cycle so the stopwatch clears during reset.
  - On the first edge with rst low, tag1 <= 0.
  - Reset mid-operation (any state, pending debounce) discards everything.
  - A button held through reset is seen as a fresh press: same latency, measured from the first post-reset edge.

Test Plan (DEBOUNCE_CYCLES=4):
1. rst high 3 cycles, then low -> during reset tag1=2, state=0, lap_valid=0, display=sw_count; tag1=0 from the first non-reset edge.
2. From IDLE, btn_start high 12 cycles -> state=1 and tag1=1 exactly on the 7th edge after assertion; exactly one transition despite the hold; release causes no change.
3. btn_start high 3 cycles, then low (glitch) -> no press; state stays 0 and tag1 stays 0 for 20 cycles.
4. In RUN with sw_count=123, lap press -> state=3, lap_valid=1, tag1=1, display=123 while sw_count ramps to 130. Second lap press -> state=1, display=sw_count.
5. In RUN, start press -> state=2, tag1=0; start again -> state=1, tag1=1. In PAUSE, lap press -> no change.
6. In LAP, btn_clear and btn_start raised on the same cycle -> state=0, tag1=2 for exactly one cycle then 0, lap_valid=0, display=sw_count. Start is ignored (state does not become RUN).

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button, count and mode signals between the stopwatch front-end and its
// environment. The master drives the buttons and the live count; the slave is the controller.
interface stopwatch_ctrl_if;
    logic        btn_start;
    logic        btn_lap;
    logic        btn_clear;
    logic [31:0] sw_count;
    logic [2:0]  tag1;
    logic [31:0] display;
    logic [1:0]  state;
    logic        lap_valid;

    modport master (
        output btn_start, btn_lap, btn_clear, sw_count,
        input  tag1, display, state, lap_valid
    );

    modport slave (
        input  btn_start, btn_lap, btn_clear, sw_count,
        output tag1, display, state, lap_valid
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: debounces start/lap/clear buttons and runs the
// run/pause/lap FSM that drives the stopwatch mode code and display mux.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] TAG_HOLD  = 3'd0;
    localparam logic [2:0] TAG_COUNT = 3'd1;
    localparam logic [2:0] TAG_CLEAR = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    // Bit order everywhere: [0] start, [1] lap, [2] clear
    logic [2:0]    w_raw;
    logic [2:0]    r_s1;
    logic [2:0]    r_s2;
    logic [2:0]    r_deb;
    logic [2:0]    r_deb_d;
    logic [CW-1:0] r_cnt [3];
    logic [2:0]    w_press;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_tag1;
    logic [2:0]    w_tag1_nxt;
    logic [31:0]   r_lap;
    logic [31:0]   w_lap_nxt;
    logic          r_lap_valid;
    logic          w_lap_valid_nxt;

    assign w_raw   = {bus.btn_clear, bus.btn_lap, bus.btn_start};
    assign w_press = r_deb & ~r_deb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tag1      <= TAG_CLEAR;
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag1      <= w_tag1_nxt;
            r_lap       <= w_lap_nxt;
            r_lap_valid <= w_lap_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lap_nxt       = r_lap;
        w_lap_valid_nxt = r_lap_valid;
        // Only the highest-priority press acts; the rest are dropped
        priority case (1'b1)
            w_press[2]: begin
                w_state_nxt     = S_IDLE;
                w_lap_nxt       = '0;
                w_lap_valid_nxt = 1'b0;
            end
            w_press[0]: begin
                unique case (r_state)
                    S_IDLE:  w_state_nxt = S_RUN;
                    S_RUN:   w_state_nxt = S_PAUSE;
                    S_PAUSE: w_state_nxt = S_RUN;
                    S_LAP:   w_state_nxt = S_PAUSE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
            w_press[1]: begin
                if (r_state == S_RUN) begin
                    w_state_nxt     = S_LAP;
                    w_lap_nxt       = bus.sw_count;
                    w_lap_valid_nxt = 1'b1;
                end else if (r_state == S_LAP) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: ;
        endcase

        if (w_press[2])
            w_tag1_nxt = TAG_CLEAR;
        else if (w_state_nxt == S_RUN || w_state_nxt == S_LAP)
            w_tag1_nxt = TAG_COUNT;
        else
            w_tag1_nxt = TAG_HOLD;
    end

    assign bus.tag1      = r_tag1;
    assign bus.state     = r_state;
    assign bus.lap_valid = r_lap_valid;
    assign bus.display   = (r_state == S_LAP) ? r_lap : bus.sw_count;
endmodule
